// File: rtl/uart_pkg.sv
// uart_pkg: UART state type and baud helper shared by uart_tx and uart_rx.
// UART_TX_PARITY_EN adds the PARITY state to the state type.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_t;

  function automatic int ticks_per_bit(
    input int clock_freq,
    input int baud_rate
  );
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts 0..TICKS-1, tick on TICKS-1.
// Ports: clock, resetn (async low), clear (sync restart to 0), tick.
module uart_baud_counter #(
  parameter int TICKS = 48
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICKS);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICKS - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter with valid/ready word input.
// Ports: clock, resetn (async low), data/valid/ready in, signal/busy out.
// Macro UART_TX_PARITY_EN inserts an even parity bit before stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 460800
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             signal,
  output logic             busy
);

  localparam int TICKS = ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  if (TICKS < 2) begin : g_bad_ticks
    $error("uart_tx: CLOCK_FREQ/BAUD_RATE must be >= 2");
  end

  uart_state_t      state;
  uart_state_t      state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_nxt;
  logic [BW-1:0]    bidx;
  logic [BW-1:0]    bidx_nxt;
  logic             line;
  logic             line_nxt;
  logic             load;
  logic             shift;
  logic             tick;
  logic             clear;

`ifdef UART_TX_PARITY_EN
  logic             par;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^data;
    end
  end
`endif

  // Baud phase restarts whenever the state changes; held at 0 in IDLE.
  assign clear = (state_nxt != state) || (state == IDLE);

  uart_baud_counter #(
    .TICKS (TICKS)
  ) u_baud (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear),
    .tick   (tick)
  );

  assign sh_nxt = shreg >> 1;
  assign ready  = (state == IDLE);
  assign busy   = !ready;
  assign signal = line;

  // line_nxt is the level for the state being entered, so the
  // registered line changes on the same edge as the state.
  always_comb begin
    state_nxt = state;
    bidx_nxt  = bidx;
    line_nxt  = 1'b1;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid) begin
          state_nxt = START;
          load      = 1'b1;
          line_nxt  = 1'b0;
        end
      end
      START: begin
        line_nxt = 1'b0;
        if (tick) begin
          state_nxt = DATA;
          line_nxt  = shreg[0];
        end
      end
      DATA: begin
        line_nxt = shreg[0];
        if (tick) begin
          shift = 1'b1;
          if (bidx == LAST) begin
            bidx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            line_nxt  = par;
`else
            state_nxt = STOP;
            line_nxt  = 1'b1;
`endif
          end else begin
            bidx_nxt = bidx + BW'(1);
            line_nxt = sh_nxt[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_nxt = par;
        if (tick) begin
          state_nxt = STOP;
          line_nxt  = 1'b1;
        end
      end
`endif
      STOP: begin
        line_nxt = 1'b1;
        if (tick) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      line  <= 1'b1;
      bidx  <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      line  <= line_nxt;
      bidx  <= bidx_nxt;
      if (load) begin
        shreg <= data;
      end else if (shift) begin
        shreg <= sh_nxt;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx.
// Line levels are predicted from frame-bit arithmetic per cycle.
module tb_uart_tx;

  localparam int WIDTH = 8;
  localparam int BAUD  = 9600;
  localparam int CLK   = 460800;
  localparam int T     = CLK / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = WIDTH + 3;
`else
  localparam int NB    = WIDTH + 2;
`endif
  localparam int FRAME = NB * T;

  logic             clock  = 1'b0;
  logic             resetn = 1'b0;
  logic             valid  = 1'b0;
  logic [WIDTH-1:0] data   = '0;
  logic             ready;
  logic             signal;
  logic             busy;

  int checks = 0;
  int passed = 0;

  logic obs_line [4096];
  logic obs_rdy  [4096];
  logic obs_busy [4096];

  uart_tx #(
    .WIDTH      (WIDTH),
    .BAUD_RATE  (BAUD),
    .CLOCK_FREQ (CLK)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .data   (data),
    .valid  (valid),
    .ready  (ready),
    .signal (signal),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  // Line level k cycles after the accepting edge (k=0: first start cycle).
  function automatic logic exp_line(input logic [WIDTH-1:0] w, input int k);
    int b;
    b = k / T;
    if (k < 0 || b >= NB) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= WIDTH) return w[b-1];
    if (b == WIDTH + 1 && NB == WIDTH + 3) return ^w;
    return 1'b1;
  endfunction

  task automatic launch(input logic [WIDTH-1:0] w);
    @(negedge clock);
    data  = w;
    valid = 1'b1;
    @(posedge clock);
  endtask

  task automatic observe(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      obs_line[k] = signal;
      obs_rdy[k]  = ready;
      obs_busy[k] = busy;
      if (k == 0) valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    int bad;
    bad = -1;
    resetn = 1'b0;
    valid  = 1'b0;
    @(negedge clock);
    checks++;
    if (signal !== 1'b1 || ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_hold got sig=%b rdy=%b busy=%b want 1 1 0",
               signal, ready, busy);
    else passed++;
    resetn = 1'b1;
    for (int k = 0; k < T; k++) begin
      @(negedge clock);
      if (bad < 0 && (signal !== 1'b1 || ready !== 1'b1 || busy !== 1'b0))
        bad = k;
    end
    checks++;
    if (bad >= 0)
      $display("FAIL reset_idle cycle %0d got sig=%b rdy=%b want 1 1",
               bad, signal, ready);
    else passed++;
  endtask

  task automatic test_first_accept;
    int bad;
    int ra;
    bad = -1;
    ra  = -1;
    @(negedge clock);
    resetn = 1'b0;
    data   = 8'hC3;
    valid  = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    observe(FRAME + 2);
    for (int k = 0; k < FRAME + 2; k++) begin
      if (bad < 0 && obs_line[k] !== exp_line(8'hC3, k)) bad = k;
      if (ra < 0 && obs_rdy[k] === 1'b1) ra = k;
    end
    checks++;
    if (bad >= 0)
      $display("FAIL first_line cycle %0d got %b want %b",
               bad, obs_line[bad], exp_line(8'hC3, bad));
    else passed++;
    checks++;
    if (ra !== FRAME)
      $display("FAIL first_ready got %0d want %0d", ra, FRAME);
    else passed++;
  endtask

  task automatic test_a5;
    int bad;
    int ra;
    int badb;
`ifdef UART_TX_PARITY_EN
    logic c [NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    logic c [NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
    bad  = -1;
    ra   = -1;
    badb = -1;
    launch(8'hA5);
    observe(FRAME + 2);
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (obs_line[i*T + T/2] !== c[i])
        $display("FAIL a5_centre bit %0d got %b want %b",
                 i, obs_line[i*T + T/2], c[i]);
      else passed++;
    end
    for (int k = 0; k < FRAME + 2; k++) begin
      if (bad < 0 && obs_line[k] !== exp_line(8'hA5, k)) bad = k;
      if (ra < 0 && obs_rdy[k] === 1'b1) ra = k;
      if (badb < 0 && obs_busy[k] !== !obs_rdy[k]) badb = k;
    end
    checks++;
    if (bad >= 0)
      $display("FAIL a5_line cycle %0d got %b want %b",
               bad, obs_line[bad], exp_line(8'hA5, bad));
    else passed++;
    checks++;
    if (ra !== FRAME)
      $display("FAIL a5_ready got %0d want %0d", ra, FRAME);
    else passed++;
    checks++;
    if (badb >= 0)
      $display("FAIL a5_busy cycle %0d got busy=%b want %b",
               badb, obs_busy[badb], !obs_rdy[badb]);
    else passed++;
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] w;
    int bad;
    int ra;
    for (int n = 0; n < 12; n++) begin
      w = WIDTH'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clock);
      checks++;
      if (ready !== 1'b1)
        $display("FAIL rand_idle_ready got %b want 1", ready);
      else passed++;
      launch(w);
      #1 data = ~w;
      observe(FRAME + 2);
      bad = -1;
      ra  = -1;
      for (int k = 0; k < FRAME + 2; k++) begin
        if (bad < 0 && obs_line[k] !== exp_line(w, k)) bad = k;
        if (ra < 0 && obs_rdy[k] === 1'b1) ra = k;
      end
      checks++;
      if (bad >= 0)
        $display("FAIL rand_line w=%h cycle %0d got %b want %b",
                 w, bad, obs_line[bad], exp_line(w, bad));
      else passed++;
      checks++;
      if (ra !== FRAME)
        $display("FAIL rand_ready w=%h got %0d want %0d", w, ra, FRAME);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    int fe;
    logic e;
    bad = -1;
    fe  = -1;
    @(negedge clock);
    data  = 8'h00;
    valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 2*FRAME + 4; k++) begin
      @(negedge clock);
      obs_line[k] = signal;
      obs_rdy[k]  = ready;
      if (k == 0) data = 8'hFF;
      if (k == FRAME + 1) valid = 1'b0;
    end
    for (int k = 0; k < 2*FRAME + 4; k++) begin
      e = (k <= FRAME) ? exp_line(8'h00, k) : exp_line(8'hFF, k - FRAME - 1);
      if (bad < 0 && obs_line[k] !== e) bad = k;
      if (k > 0 && fe < 0 && obs_line[k-1] === 1'b1 && obs_line[k] === 1'b0)
        fe = k;
    end
    checks++;
    if (bad >= 0)
      $display("FAIL b2b_line cycle %0d got %b", bad, obs_line[bad]);
    else passed++;
    checks++;
    if (fe !== FRAME + 1)
      $display("FAIL b2b_gap got %0d want %0d", fe, FRAME + 1);
    else passed++;
    checks++;
    if (obs_rdy[FRAME] !== 1'b1 || obs_rdy[FRAME+1] !== 1'b0)
      $display("FAIL b2b_idle_ready got %b%b want 10",
               obs_rdy[FRAME], obs_rdy[FRAME+1]);
    else passed++;
    checks++;
    if (obs_rdy[2*FRAME] !== 1'b0 || obs_rdy[2*FRAME+1] !== 1'b1)
      $display("FAIL b2b_end_ready got %b%b want 01",
               obs_rdy[2*FRAME], obs_rdy[2*FRAME+1]);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    int bad;
    int ra;
    bad = -1;
    ra  = -1;
    launch(8'h00);
    for (int k = 0; k <= 200; k++) begin
      @(negedge clock);
      obs_line[k] = signal;
      if (k == 0) valid = 1'b0;
    end
    checks++;
    if (obs_line[200] !== exp_line(8'h00, 200))
      $display("FAIL mid_before got %b want %b",
               obs_line[200], exp_line(8'h00, 200));
    else passed++;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (signal !== 1'b1)
      $display("FAIL mid_async_signal got %b want 1", signal);
    else passed++;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_async_ready got rdy=%b busy=%b want 1 0",
               ready, busy);
    else passed++;
    @(negedge clock);
    resetn = 1'b1;
    launch(8'h3C);
    observe(FRAME + 2);
    for (int k = 0; k < FRAME + 2; k++) begin
      if (bad < 0 && obs_line[k] !== exp_line(8'h3C, k)) bad = k;
      if (ra < 0 && obs_rdy[k] === 1'b1) ra = k;
    end
    checks++;
    if (bad >= 0)
      $display("FAIL mid_3c_line cycle %0d got %b want %b",
               bad, obs_line[bad], exp_line(8'h3C, bad));
    else passed++;
    checks++;
    if (ra !== FRAME)
      $display("FAIL mid_3c_ready got %0d want %0d", ra, FRAME);
    else passed++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int ra;
    ra = -1;
    launch(8'h07);
    observe(FRAME + 2);
    for (int k = 0; k < FRAME + 2; k++)
      if (ra < 0 && obs_rdy[k] === 1'b1) ra = k;
    checks++;
    if (obs_line[(WIDTH+1)*T + T/2] !== 1'b1)
      $display("FAIL par07_bit got %b want 1", obs_line[(WIDTH+1)*T + T/2]);
    else passed++;
    checks++;
    if (ra !== 528)
      $display("FAIL par07_len got %0d want 528", ra);
    else passed++;
    launch(8'h03);
    observe(FRAME + 2);
    checks++;
    if (obs_line[(WIDTH+1)*T + T/2] !== 1'b0)
      $display("FAIL par03_bit got %b want 0", obs_line[(WIDTH+1)*T + T/2]);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_first_accept();
    test_a5();
    test_random();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
